// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: byte FIFO fed by CPU write strobes, serialised as 8N1 frames.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1).
module uart_tx_mmio #(
    parameter int unsigned CLK_HZ     = 23000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    input  logic                          clr_ovf,
    output logic                          tx,
    output logic                          full,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = $clog2(DIV);

    localparam logic [CW-1:0] BaudLast = CW'(DIV - 1);
    localparam logic [AW:0]   DepthVal = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
        StParity = 3'd3,
`endif
        StStop   = 3'd4
    } state_e;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;

    state_e        state_q;
    logic [CW-1:0] baud_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shreg_q;
    logic          tx_q;
`ifdef UART_TX_PARITY_EN
    logic          parity_q;
`endif

    logic full_w, nonempty, bit_end, push, pop;

    assign full_w   = (count_q == DepthVal);
    assign nonempty = (count_q != '0);
    assign bit_end  = (baud_q == BaudLast);
    assign push     = wr_en && !full_w;
    // The FSM takes the next byte when idle or exactly at the end of a stop bit.
    assign pop      = nonempty && ((state_q == StIdle) || ((state_q == StStop) && bit_end));

    always_comb begin
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A dropped write beats a simultaneous clear.
        if (wr_en && full_w) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    tx_q   <= 1'b1;
                    baud_q <= '0;
                    if (pop) begin
                        shreg_q  <= mem_q[rptr_q];
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^mem_q[rptr_q];
`endif
                        tx_q     <= 1'b0;
                        state_q  <= StStart;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= shreg_q[0];
                        state_q   <= StData;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= StParity;
`else
                            tx_q    <= 1'b1;
                            state_q <= StStop;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shreg_q[bit_idx_q + 3'd1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                        state_q <= StStop;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`endif
                StStop: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (pop) begin
                            shreg_q  <= mem_q[rptr_q];
`ifdef UART_TX_PARITY_EN
                            parity_q <= ^mem_q[rptr_q];
`endif
                            tx_q     <= 1'b0;
                            state_q  <= StStart;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= StIdle;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    baud_q  <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign full     = full_w;
    assign busy     = (state_q != StIdle) || nonempty;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with DIV=4, FIFO_DEPTH=8; a line monitor decodes frames.
module tb_uart_tx_mmio;

    localparam int unsigned DIV = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       clr_ovf = 1'b0;
    logic       tx, full, busy, overflow;
    logic [3:0] count;

    uart_tx_mmio #(
        .CLK_HZ     (400),
        .BAUD       (100),
        .FIFO_DEPTH (8)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .clr_ovf  (clr_ovf),
        .tx       (tx),
        .full     (full),
        .busy     (busy),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] byte_q[$];
    int         start_q[$];
    logic       stop_q[$];
    logic       par_q[$];

    // Decodes frames by sampling each bit in the middle of its period.
    initial begin : line_mon
        logic [7:0] d;
        logic       p;
        int         t0;
        forever begin
            @(negedge clk);
            if (rstn && tx === 1'b0) begin
                t0 = cyc;
                repeat (2) @(negedge clk);
                for (int j = 0; j < 8; j++) begin
                    repeat (4) @(negedge clk);
                    d[j] = tx;
                end
                p = 1'b0;
`ifdef UART_TX_PARITY_EN
                repeat (4) @(negedge clk);
                p = tx;
`endif
                repeat (4) @(negedge clk);
                byte_q.push_back(d);
                start_q.push_back(t0);
                stop_q.push_back(tx);
                par_q.push_back(p);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        byte_q.delete();
        start_q.delete();
        stop_q.delete();
        par_q.delete();
    endtask

    task automatic wait_idle(input string tag);
        for (int n = 0; n < 2000; n++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check(tag, 32'(busy), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_byte(input string tag, input int idx, input logic [7:0] exp);
        if (byte_q.size() > idx) begin
            check(tag, 32'(byte_q[idx]), 32'(exp));
            check({tag, "_stop"}, 32'(stop_q[idx]), 1);
        end else begin
            check({tag, "_missing"}, 32'(byte_q.size()), 32'(idx + 1));
        end
    endtask

    // Writes one burst of 10 bytes; optionally clears overflow on the dropped write.
    task automatic burst10(input string tag, input logic clr_on_drop);
        for (int i = 0; i < 10; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            clr_ovf = (i == 9) ? clr_on_drop : 1'b0;
            @(negedge clk);
            if (i == 1) begin
                check({tag, "_tx_e1"}, 32'(tx), 0);
                check({tag, "_cnt_e1"}, 32'(count), 1);
            end
            if (i == 7) check({tag, "_full_e7"}, 32'(full), 0);
            if (i == 8) begin
                check({tag, "_full_e8"}, 32'(full), 1);
                check({tag, "_cnt_e8"}, 32'(count), 8);
                check({tag, "_ovf_e8"}, 32'(overflow), 0);
            end
            if (i == 9) begin
                check({tag, "_ovf_e9"}, 32'(overflow), 1);
                check({tag, "_cnt_e9"}, 32'(count), 8);
            end
        end
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
    endtask

    initial begin
        int n;
        int lows;

        @(negedge clk);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 1);
        check("rst_full", 32'(full), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_count", 32'(count), 0);
        check("rst_ovf", 32'(overflow), 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0x55
        wr_en = 1'b1;
        wr_data = 8'h55;
        @(negedge clk);
        wr_en = 1'b0;
        check("t1_cnt_e0", 32'(count), 1);
        check("t1_tx_e0", 32'(tx), 1);
        @(negedge clk);
        check("t1_tx_start", 32'(tx), 0);
        check("t1_cnt_e1", 32'(count), 0);
        check("t1_busy", 32'(busy), 1);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
            if (n == DIV - 1) check("t1_start_end", 32'(tx), 0);
            if (n == DIV) check("t1_bit0", 32'(tx), 1);
            if (n == DIV * 2) check("t1_bit1", 32'(tx), 0);
        end
        check("t1_busy_len", 32'(n), 32'(DIV * NBITS));
        repeat (4) @(negedge clk);
        check("t1_nframes", 32'(byte_q.size()), 1);
        check_byte("t1_byte", 0, 8'h55);
        clear_q();

        // Back-to-back 0xA3, 0x0F
        wr_en = 1'b1;
        wr_data = 8'hA3;
        @(negedge clk);
        wr_data = 8'h0F;
        @(negedge clk);
        wr_en = 1'b0;
        wait_idle("t2_idle");
        check("t2_nframes", 32'(byte_q.size()), 2);
        check_byte("t2_byte0", 0, 8'hA3);
        check_byte("t2_byte1", 1, 8'h0F);
        if (start_q.size() >= 2) check("t2_gap", 32'(start_q[1] - start_q[0]), 32'(DIV * NBITS));
        clear_q();

        // Overflow, then explicit clear
        burst10("t3", 1'b0);
        @(negedge clk);
        check("t3_ovf_sticky", 32'(overflow), 1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("t3_ovf_clr", 32'(overflow), 0);
        wait_idle("t3_idle");
        check("t3_nframes", 32'(byte_q.size()), 9);
        for (int i = 0; i < 9; i++) check_byte("t3_byte", i, 8'(i));
        clear_q();

        // Clear colliding with a dropped write
        burst10("t4", 1'b1);
        @(negedge clk);
        check("t4_ovf_hold", 32'(overflow), 1);
        wait_idle("t4_idle");
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        clear_q();

        // Reset during data bit 3 with two bytes queued
        wr_en = 1'b1;
        wr_data = 8'hFF;
        @(negedge clk);
        wr_data = 8'h11;
        @(negedge clk);
        check("t5_tx_start", 32'(tx), 0);
        wr_data = 8'h22;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (16) @(negedge clk);
        check("t5_cnt_pre", 32'(count), 2);
        rstn = 1'b0;
        @(negedge clk);
        check("t5_tx", 32'(tx), 1);
        check("t5_count", 32'(count), 0);
        check("t5_busy", 32'(busy), 0);
        rstn = 1'b1;
        lows = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        check("t5_quiet", 32'(lows), 0);
        clear_q();

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x07 -> 1, 0x03 -> 0
        wr_en = 1'b1;
        wr_data = 8'h07;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t6_len", 32'(n), 44);
        repeat (4) @(negedge clk);
        check_byte("t6_byte07", 0, 8'h07);
        if (par_q.size() >= 1) check("t6_par07", 32'(par_q[0]), 1);
        clear_q();
        wr_en = 1'b1;
        wr_data = 8'h03;
        @(negedge clk);
        wr_en = 1'b0;
        wait_idle("t6_idle");
        check_byte("t6_byte03", 0, 8'h03);
        if (par_q.size() >= 1) check("t6_par03", 32'(par_q[0]), 0);
        clear_q();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter that lets the CPU send bytes out on the board `tx` pin. Store data arrives from the MemOrIO write path as one-cycle write strobes. Bytes are buffered in a small FIFO and serialised LSB-first as 8N1 frames (optionally 8E1). Status outputs feed back to the CPU read-data mux so software can poll before writing.

## Interface
Parameters:
- `CLK_HZ`, 23000000, CPU clock frequency in Hz.
- `BAUD`, 115200, line rate. Bit period `DIV = CLK_HZ/BAUD` (integer division, must be ≥ 2).
- `FIFO_DEPTH`, 8, number of bytes buffered. Must be a power of two, ≥ 2.

Ports:
- `clk`, in, 1, CPU clock. Single clock domain.
- `rstn`, in, 1, reset; synchronous, active-low.
- `wr_en`, in, 1, one-cycle write strobe (ioWrite decoded for the TX data address).
- `wr_data`, in, 8, byte to send; sampled when `wr_en`=1.
- `clr_ovf`, in, 1, clears `overflow`.
- `tx`, out, 1, serial line; idle high.
- `full`, out, 1, FIFO holds `FIFO_DEPTH` bytes.
- `busy`, out, 1, FIFO non-empty or a frame is on the line.
- `count`, out, log2(FIFO_DEPTH)+1, bytes currently in the FIFO (excludes the byte being shifted).
- `overflow`, out, 1, sticky flag: a write was dropped because the FIFO was full.

## Operation
- FIFO: circular buffer with read/write pointers and a count.
  - Push when `wr_en && !full`. `full` is evaluated from the count at the start of the cycle.
  - A write to a full FIFO is dropped and sets `overflow`, even if a pop happens in the same cycle.
  - Simultaneous push and pop leaves `count` unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- FSM states and transitions:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: `tx`=0 for DIV cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held DIV cycles. A 3-bit bit index advances at each bit boundary. After bit 7, go to PARITY if enabled, else STOP.
  - PARITY (macro only): even parity (XOR of the 8 data bits) for DIV cycles, then go to STOP.
  - STOP: `tx`=1 for DIV cycles. At the end of the stop bit:
    - FIFO non-empty: pop and go directly to START (no idle gap between frames).
    - FIFO empty: go to IDLE.
- Baud counter counts 0..DIV-1. It resets on every state entry and every bit boundary.
- `tx` is driven from a register, so it is glitch-free.
- `overflow`:
  - Set by a dropped write; cleared by `clr_ovf`.
  - If both occur in the same cycle, set wins.
- `busy` = (state≠IDLE) || (count≠0).

## Timing
- Reset values: `tx`=1, `full`=0, `busy`=0, `count`=0, `overflow`=0, FSM=IDLE, FIFO pointers=0.
- Reset during a frame aborts it. `tx`=1 from the first cycle after the reset edge, and FIFO contents are discarded.
- Latency from an empty, idle block:
  - `wr_en` sampled at edge 0.
  - `count`=1 after edge 0.
  - IDLE pops at edge 1.
  - `tx` goes low after edge 1, i.e. 2 edges after the write.
- Frame length: 10·DIV cycles (11·DIV with parity). Back-to-back frames have no gap.
- `count`, `full` and `overflow` update on the edge that causes the change. The CPU observes them one cycle after its store.
- `wr_en` may be held high on consecutive cycles; each high cycle is one write attempt.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in. Frame is start + 8 data + even parity + stop (8E1, 11 bits).
- `UART_TX_PARITY_EN` undefined: no PARITY state or parity logic. Frame is 8N1, 10 bits.

## Test plan
All scenarios use `CLK_HZ`=400, `BAUD`=100 (DIV=4) and `FIFO_DEPTH`=8.
- **Single byte:** write 0x55 at edge 0.
  - `tx` low for cycles 2–5, then data bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high for the stop bit.
  - `busy` falls 40 cycles after `tx` first goes low.
  - `count` returns to 0 at cycle 2.
- **Back-to-back:** write 0xA3 then 0x0F on consecutive cycles.
  - The start bit of frame 2 begins exactly 40 cycles after the start bit of frame 1.
  - Decoded line bytes are 0xA3, 0x0F.
- **Overflow:** write 10 bytes (0x00–0x09) on consecutive cycles.
  - Byte 0 is popped at edge 1; `full`=1 after edge 8; byte 0x09 is dropped; `overflow`=1.
  - The line carries 0x00–0x08.
  - Pulsing `clr_ovf` then gives `overflow`=0.
- **Reset mid-frame:** write 0xFF; assert `rstn`=0 during DATA bit 3 while two more bytes are queued.
  - `tx`=1, `count`=0 and `busy`=0 on the cycle after the reset edge.
  - No further frames are sent.
- **Parity (`UART_TX_PARITY_EN` defined):** write 0x07.
  - Parity bit is 1; frame length is 44 cycles.
  - Writing 0x03 gives parity bit 0.
- **Set/clear collision:** assert `clr_ovf` in the same cycle as a dropped write → `overflow` remains 1.
